shift_sub_divider_8: RTL and testbench

- Unsigned 8-bit sequential divider using the restoring shift-subtract method, one quotient bit per clock.
- It is the inverse datapath of the lab's add-shift multiplier:
  - the multiplier shifts right and adds;
  - this block shifts left and performs a trial subtract.
- Sits beside the multiplier in the lab top level. Operands come from switches, and results drive hex displays/LEDs.

---
 rtl/shift_sub_divider_8_pkg.sv | 6 +
 rtl/shift_sub_divider_8_if.sv | 13 +
 rtl/shift_sub_divider_8_shift_left_reg_n.sv | 33 +++
 rtl/shift_sub_divider_8.sv | 90 +++++++++
 tb/tb_shift_sub_divider_8.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/shift_sub_divider_8_pkg.sv
// Shared types and constants for the restoring shift-subtract divider.
package div_pkg;
  localparam int DIV_W = 8;
  localparam int CNT_W = $clog2(DIV_W);
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
endpackage

// File: rtl/shift_sub_divider_8_if.sv
// Operand/result bundle between the lab top level (switches, displays) and the divider.
interface shift_sub_divider_8_if import div_pkg::*; #(parameter int N = DIV_W);
  logic         Run;
  logic [N-1:0] Dividend;
  logic [N-1:0] Divisor;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         Done;
  logic         DivByZero;

  modport master (output Run, Dividend, Divisor, input Quotient, Remainder, Done, DivByZero);
  modport slave  (input Run, Dividend, Divisor, output Quotient, Remainder, Done, DivByZero);
endinterface

// File: rtl/shift_sub_divider_8_shift_left_reg_n.sv
// Combined A:Q left-shift register: sync clear, parallel load, shift with bit-0 insert,
// and an optional overwrite of the upper HI bits on the same shift edge.
module shift_left_reg_n import div_pkg::*; #(
  parameter int W  = 2*DIV_W+1,
  parameter int HI = DIV_W+1
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          ld_i,
  input  logic [W-1:0]  d_i,
  input  logic          sh_i,
  input  logic          b0_i,
  input  logic          ldhi_i,
  input  logic [HI-1:0] hi_i,
  output logic [W-1:0]  q_o
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i)     q_d = '0;
    else if (ld_i) q_d = d_i;
    else if (sh_i) begin
      q_d = {q_q[W-2:0], b0_i};
      // Successful trial subtract replaces the shifted remainder with the difference.
      if (ldhi_i) q_d[W-1 -: HI] = hi_i;
    end
  end

  always_ff @(posedge clk_i) q_q <= q_d;

  assign q_o = q_q;
endmodule

// File: rtl/shift_sub_divider_8.sv
// Unsigned restoring divider, one quotient bit per clock; results exposed only from
// output registers loaded on entry to DONE.
module shift_sub_divider_8 import div_pkg::*; #(
  parameter int N = DIV_W
) (
  input logic Clk,
  input logic Reset,
  shift_sub_divider_8_if.slave bus
);
  localparam int CW = $clog2(N);

  div_state_t   state_q;
  logic [N-1:0] b_q, quo_q, rem_q;
  logic [CW-1:0] cnt_q;
  logic         done_q, dbz_q;

  logic [2*N:0] aq;
  logic [N:0]   a_sh;
  logic [N+1:0] diff;
  logic         neg, start, calc;
  logic         unused_a_msb;

  // A' = {A[N-1:0], Q[N-1]} is simply the upper N+1 bits of A:Q seen one place down.
  assign a_sh         = aq[2*N-1:N-1];
  assign diff         = {1'b0, a_sh} - {2'b00, b_q};
  assign neg          = diff[N+1];
  assign start        = (state_q == IDLE) && bus.Run;
  assign calc         = (state_q == CALC);
  assign unused_a_msb = aq[2*N];

  shift_left_reg_n #(.W(2*N+1), .HI(N+1)) u_aq (
    .clk_i  (Clk),
    .clr_i  (Reset),
    .ld_i   (start),
    .d_i    ({{(N+1){1'b0}}, bus.Dividend}),
    .sh_i   (calc),
    .b0_i   (~neg),
    .ldhi_i (calc && !neg),
    .hi_i   (diff[N:0]),
    .q_o    (aq)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      b_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.Run) begin
          b_q   <= bus.Divisor;
          cnt_q <= '0;
          if (bus.Divisor == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            dbz_q   <= 1'b1;
            quo_q   <= '1;
            rem_q   <= bus.Dividend;
          end else begin
            state_q <= CALC;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N-1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            quo_q   <= {aq[N-2:0], ~neg};
            rem_q   <= neg ? a_sh[N-1:0] : diff[N-1:0];
          end
        end
        DONE: if (!bus.Run) begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          dbz_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Quotient  = quo_q;
  assign bus.Remainder = rem_q;
  assign bus.Done      = done_q;
  assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_shift_sub_divider_8.sv
// Bench for shift_sub_divider_8: directed vector table, corner sequences, random sweep.
module tb_shift_sub_divider_8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  shift_sub_divider_8_if bus ();
  shift_sub_divider_8 dut (.Clk(clk), .Reset(rst), .bus(bus.slave));

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Starts an operation and waits for Done; lat counts rising edges from the start edge on.
  task automatic run_op(input logic [7:0] dvd, input logic [7:0] dvs, input bit pulse,
                        input bit chg, input logic [7:0] ndvd, input logic [7:0] ndvs,
                        output logic [7:0] q, output logic [7:0] r, output logic dbz,
                        output int lat);
    @(negedge clk);
    bus.Dividend = dvd;
    bus.Divisor  = dvs;
    bus.Run      = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    if (pulse) bus.Run = 1'b0;
    if (chg) begin
      bus.Dividend = ndvd;
      bus.Divisor  = ndvs;
    end
    forever begin
      @(negedge clk);
      if (bus.Done) break;
      if (lat > 40) begin
        lat = -1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    q   = bus.Quotient;
    r   = bus.Remainder;
    dbz = bus.DivByZero;
  endtask

  task automatic release_run();
    @(negedge clk);
    bus.Run = 1'b0;
    @(negedge clk);
    chk("done_clears", int'(bus.Done), 0);
  endtask

  logic [7:0] q, r, hq, hr;
  logic       dbz;
  int         lat, bad;

  initial begin
    bus.Run = 1'b0;
    bus.Dividend = '0;
    bus.Divisor = '0;
    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9};
    vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9};
    vecs[4] = '{8'd200, 8'd0,   8'hFF,  8'd200, 1'b1, 1};
    vecs[5] = '{8'd77,  8'd5,   8'd15,  8'd2,   1'b0, 9};
    vecs[6] = '{8'd200, 8'd3,   8'd66,  8'd2,   1'b0, 9};
    vecs[7] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9};
    vecs[8] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 9};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_quo", int'(bus.Quotient), 0);
    chk("reset_rem", int'(bus.Remainder), 0);
    chk("reset_done", int'(bus.Done), 0);
    chk("reset_dbz", int'(bus.DivByZero), 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].dvd, vecs[i].dvs, 1'b1, 1'b0, 8'd0, 8'd0, q, r, dbz, lat);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_quo", i), int'(q), int'(vecs[i].q));
      chk($sformatf("vec%0d_rem", i), int'(r), int'(vecs[i].r));
      chk($sformatf("vec%0d_dbz", i), int'(dbz), int'(vecs[i].dbz));
      release_run();
    end

    // Run held high: one operation only, outputs frozen.
    run_op(8'd100, 8'd7, 1'b0, 1'b0, 8'd0, 8'd0, q, r, dbz, lat);
    chk("hold_lat", lat, 9);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!bus.Done || bus.Quotient != 8'd14 || bus.Remainder != 8'd2) bad++;
    end
    chk("hold_stable_bad_cycles", bad, 0);
    release_run();
    chk("hold_quo_kept", int'(bus.Quotient), 14);
    chk("hold_rem_kept", int'(bus.Remainder), 2);
    run_op(8'd77, 8'd5, 1'b1, 1'b0, 8'd0, 8'd0, q, r, dbz, lat);
    chk("after_hold_quo", int'(q), 15);
    chk("after_hold_rem", int'(r), 2);
    release_run();

    // Reset sampled on the 4th CALC edge aborts the operation.
    @(negedge clk);
    bus.Dividend = 8'd200;
    bus.Divisor  = 8'd3;
    bus.Run      = 1'b1;
    @(posedge clk);
    #1 bus.Run = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_quo", int'(bus.Quotient), 0);
    chk("abort_rem", int'(bus.Remainder), 0);
    chk("abort_done", int'(bus.Done), 0);
    chk("abort_dbz", int'(bus.DivByZero), 0);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.Done) bad++;
    end
    chk("abort_stays_idle", bad, 0);
    run_op(8'd200, 8'd3, 1'b1, 1'b0, 8'd0, 8'd0, q, r, dbz, lat);
    chk("post_abort_quo", int'(q), 66);
    chk("post_abort_rem", int'(r), 2);
    release_run();

    // Operands switched right after capture must not disturb the result.
    run_op(8'd100, 8'd7, 1'b1, 1'b1, 8'd9, 8'd9, q, r, dbz, lat);
    chk("opchg_quo", int'(q), 14);
    chk("opchg_rem", int'(r), 2);
    release_run();

    // Random sweep against plain integer division.
    for (int k = 0; k < 200; k++) begin
      int a, b, eq, er;
      a  = int'($urandom_range(255, 0));
      b  = int'($urandom_range(255, 1));
      eq = a / b;
      er = a % b;
      run_op(8'(a), 8'(b), k[0], 1'b0, 8'd0, 8'd0, q, r, dbz, lat);
      chk($sformatf("rnd_%0d/%0d_lat", a, b), lat, 9);
      chk($sformatf("rnd_%0d/%0d_quo", a, b), int'(q), eq);
      chk($sformatf("rnd_%0d/%0d_rem", a, b), int'(r), er);
      chk($sformatf("rnd_%0d/%0d_inv", a, b), int'(q) * b + int'(r), a);
      chk($sformatf("rnd_%0d/%0d_rlt", a, b), int'(int'(r) < b), 1);
      release_run();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
